// File: rtl/seq_mul_ctrl.sv
// Multi-cycle unsigned shift-and-add multiplier for the EX stage.
// start/busy/done handshake, flush cancels an in-flight multiply, registered product halves.
module seq_mul_ctrl #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         flush,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] product_lo,
  output logic [N-1:0] product_hi
);

  localparam int CW = $clog2(N) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  acc_sum;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            last;

  assign accept  = start && ((state == S_IDLE) || (state == S_DONE));
  assign last    = (cnt == CW'(N - 1));
  // operands are at most N bits each, so the 2N-bit sum never carries out
  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RUN;
      S_RUN: begin
        if (flush)     state_nxt = S_IDLE;
        else if (last) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
      product_lo <= '0;
      product_hi <= '0;
    end else if (accept) begin
      mcand  <= {{N{1'b0}}, a};
      mplier <= b;
      acc    <= '0;
      cnt    <= '0;
    end else if (state == S_RUN) begin
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      acc    <= acc_sum;
      cnt    <= cnt + CW'(1);
      // product latches only on the edge entering DONE; a flush leaves it untouched
      if (last && !flush) begin
        product_lo <= acc_sum[N-1:0];
        product_hi <= acc_sum[2*N-1:N];
      end
    end
  end

endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Bench for seq_mul_ctrl: N=8 and N=32 instances, directed plus random operations,
// expected products from plain a*b arithmetic and expected timing from the handshake rules.
module tb_seq_mul_ctrl;

  logic        clk = 1'b0;
  logic        rst8, start8, flush8, busy8, done8;
  logic [7:0]  a8, b8, lo8, hi8;
  logic        rst32, start32, flush32, busy32, done32;
  logic [31:0] a32, b32, lo32, hi32;

  int vecs = 0;
  int errs = 0;
  logic [15:0] held8 = '0;

  always #5 clk = ~clk;

  seq_mul_ctrl #(.N(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .flush(flush8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .product_lo(lo8), .product_hi(hi8)
  );

  seq_mul_ctrl #(.N(32)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .flush(flush32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .product_lo(lo32), .product_hi(hi32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the N=8 unit idle or in DONE. poke in 1..7 selects the RUN
  // cycle for a stray start (pflush=0) or a flush (pflush=1); poke=0 means none.
  task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input bit hold,
                      input bit fl_start, input int poke, input bit pflush, input string tag);
    logic [15:0] exp;
    bit flushed;
    exp     = 16'(ia) * 16'(ib);
    flushed = 1'b0;
    a8 = ia; b8 = ib; start8 = 1'b1; flush8 = fl_start;
    @(negedge clk);
    start8 = hold; flush8 = 1'b0;
    for (int i = 1; i <= 8 && !flushed; i++) begin
      if (i > 1) @(negedge clk);
      chk({tag, " run busy/done"}, {62'd0, busy8, done8}, 64'd2);
      if (i == poke && pflush) begin
        flush8 = 1'b1;
        @(negedge clk);
        flush8 = 1'b0;
        chk({tag, " flush idle"}, {62'd0, busy8, done8}, 64'd0);
        chk({tag, " flush product held"}, {48'd0, hi8, lo8}, {48'd0, held8});
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          chk({tag, " no done after flush"}, {62'd0, busy8, done8}, 64'd0);
        end
        flushed = 1'b1;
      end else if (i == poke) begin
        a8 = 8'($urandom); b8 = 8'($urandom); start8 = 1'b1;
      end else if (poke > 0 && i == poke + 1) begin
        start8 = hold;
      end
    end
    if (!flushed) begin
      @(negedge clk);
      chk({tag, " done pulse"}, {62'd0, busy8, done8}, 64'd1);
      chk({tag, " product"}, {48'd0, hi8, lo8}, {48'd0, exp});
      held8 = exp;
    end
  endtask

  task automatic run32(input logic [31:0] ia, input logic [31:0] ib, input string tag);
    logic [63:0] exp;
    exp = 64'(ia) * 64'(ib);
    a32 = ia; b32 = ib; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      if (i > 1) @(negedge clk);
      chk({tag, " run busy/done"}, {62'd0, busy32, done32}, 64'd2);
    end
    @(negedge clk);
    chk({tag, " done pulse"}, {62'd0, busy32, done32}, 64'd1);
    chk({tag, " product"}, {hi32, lo32}, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst8 = 1'b1; start8 = 1'b0; flush8 = 1'b0; a8 = '0; b8 = '0;
    rst32 = 1'b1; start32 = 1'b0; flush32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    chk("reset8 outputs", {46'd0, busy8, done8, hi8, lo8}, 64'd0);
    chk("reset32 outputs", {62'd0, busy32, done32}, 64'd0);
    chk("reset32 product", {hi32, lo32}, 64'd0);
    rst8 = 1'b0; rst32 = 1'b0;
    @(negedge clk);
    chk("idle after reset", {62'd0, busy8, done8}, 64'd0);

    run8(8'd13, 8'd11, 1'b0, 1'b0, 0, 1'b0, "13x11");
    @(negedge clk);
    chk("done one cycle", {62'd0, busy8, done8}, 64'd0);
    run8(8'd255, 8'd255, 1'b0, 1'b0, 0, 1'b0, "255x255");
    run8(8'd0, 8'd200, 1'b0, 1'b0, 0, 1'b0, "0x200");

    // start held high: second op accepted from DONE, no idle gap
    run8(8'd3, 8'd5, 1'b1, 1'b0, 0, 1'b0, "b2b 3x5");
    run8(8'd7, 8'd9, 1'b0, 1'b0, 0, 1'b0, "b2b 7x9");
    @(negedge clk);

    run8(8'd20, 8'd10, 1'b0, 1'b0, 3, 1'b0, "ignore start");
    @(negedge clk);
    run8(8'd13, 8'd11, 1'b0, 1'b0, 0, 1'b0, "143 again");
    @(negedge clk);
    run8(8'd100, 8'd2, 1'b0, 1'b0, 4, 1'b1, "flush");
    run8(8'd100, 8'd2, 1'b0, 1'b0, 0, 1'b0, "after flush");

    flush8 = 1'b1;
    @(negedge clk);
    flush8 = 1'b0;
    chk("flush in idle", {46'd0, busy8, done8, hi8, lo8}, {48'd0, held8});
    run8(8'd9, 8'd6, 1'b0, 1'b1, 0, 1'b0, "start beats flush");

    for (int n = 0; n < 24; n++) begin
      int gap, mode;
      gap  = int'($urandom_range(0, 2));
      mode = int'($urandom_range(0, 5));
      for (int g = 0; g < gap; g++) @(negedge clk);
      if (mode == 0)
        run8(8'($urandom), 8'($urandom), 1'b0, 1'b0, int'($urandom_range(1, 7)), 1'b1, "rand flush");
      else if (mode == 1)
        run8(8'($urandom), 8'($urandom), 1'b0, 1'b0, int'($urandom_range(1, 7)), 1'b0, "rand poke");
      else
        run8(8'($urandom), 8'($urandom), 1'b0, 1'b0, 0, 1'b0, "rand op");
    end

    run32($urandom, $urandom, "n32 warmup");
    a32 = $urandom; b32 = $urandom; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (10) @(negedge clk);
    chk("n32 busy before reset", {62'd0, busy32, done32}, 64'd2);
    rst32 = 1'b1;
    @(negedge clk);
    rst32 = 1'b0;
    chk("n32 reset mid-run flags", {62'd0, busy32, done32}, 64'd0);
    chk("n32 reset mid-run product", {hi32, lo32}, 64'd0);
    @(negedge clk);
    chk("n32 idle after reset", {62'd0, busy32, done32}, 64'd0);
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, "n32 max");
    @(negedge clk);
    run32($urandom, $urandom, "n32 rand");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/seq_mul_ctrl.md
# seq_mul_ctrl

Multi-cycle shift-and-add multiplier controller for the EX stage, executing unsigned N×N multiplies for M-extension instructions. It sequences three internal operand registers, each with load and shift capability: a left-shifting multiplicand, a right-shifting multiplier and an accumulator. It exposes a start/busy/done handshake so the hazard unit can stall the pipeline while a multiply is in flight. A flush input cancels an in-flight operation when the EX instruction is squashed.

## Interface
- N, default 32: operand width; the product is 2N bits; N must be a power of two, ≥ 4.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; sampled on rising clk.
- start  input  1  request a multiply; sampled only when busy=0.
- flush  input  1  cancel the in-flight operation; ignored when idle.
- a  input  N  multiplicand, sampled on the accepting edge only.
- b  input  N  multiplier, sampled on the accepting edge only.
- busy  output  1  operation in progress; the stall request to the hazard unit.
- done  output  1  single-cycle pulse; product valid.
- product_lo  output  N  low half of a×b (MUL result).
- product_hi  output  N  high half of a×b (MULHU result).

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: busy=0, done=0. If start=1, the FSM:
  - loads the multiplicand register (2N bits) with {N'b0, a};
  - loads the multiplier register (N bits) with b;
  - clears the accumulator (2N bits);
  - clears the cycle counter (log2(N)+1 bits);
  - moves to RUN.
- RUN: busy=1. Each cycle:
  - if multiplier[0]=1, accumulator ← accumulator + multiplicand (2N-bit add; carry-out cannot occur and is discarded);
  - multiplicand shifts left 1, zero fill;
  - multiplier shifts right 1, zero fill;
  - counter increments.
- After the N-th RUN cycle (counter = N−1 when sampled), the FSM moves to DONE.
- DONE: done=1, busy=0, for exactly one cycle. The FSM then returns to IDLE. If start=1 in DONE, it accepts a new operation and goes directly to RUN (back-to-back).
- product_lo and product_hi are driven from registered copies. They update only on the edge that enters DONE and hold until the next entry to DONE. Loading new operands does not alter them.
- start while busy=1: ignored; the operands are not re-sampled.
- flush=1 in RUN: next state is IDLE. No done pulse; product outputs are unchanged.
- flush=1 and start=1 in IDLE or DONE: start wins; flush applies only to RUN.
- reset=1 overrides all inputs, in any state including mid-RUN. On the next edge:
  - state=IDLE;
  - all internal registers and product_lo/product_hi are 0;
  - busy=0, done=0.
- Operands of 0 are not special-cased: the latency is fixed at N cycles regardless of data.

## Timing
- Accept edge E0: start=1 while busy=0.
- busy=1 from just after E0 through edge E0+N; RUN occupies N cycles.
- done=1 and product valid in the cycle after edge E0+N, until edge E0+N+1.
- Start-to-done latency is N+1 cycles. Back-to-back throughput is one result per N+1 cycles.
- busy and done are never simultaneously 1.
- Outputs are registered state decodes; there are no combinational paths from inputs to outputs.
- After reset deasserts, the first accepted start is on the first edge where reset=0 and start=1.

## Test plan
- N=8; reset then a=13, b=11, start pulsed for one cycle → busy high for 8 cycles; done 9 cycles after the accept edge; product_lo=143 (0x8F), product_hi=0.
- N=8; a=255, b=255 → product_hi=0xFE, product_lo=0x01 (65025); then a=0, b=200 → both halves 0 after 8 RUN cycles, with the identical latency.
- N=8; start=1 held continuously with a=3,b=5 then a=7,b=9 presented in the DONE cycle → done pulses 9 cycles apart; results 15 then 63, with no idle cycle between operations.
- N=8; start a=20, b=10; change a/b and pulse start again at RUN cycle 3 → second start ignored; result 200; done still 9 cycles after the first accept.
- N=8; a prior result of 143 is held; start a=100, b=2; flush=1 at RUN cycle 4 → next cycle IDLE, busy=0, no done pulse, product stays 143; a new start then yields its correct result.
- N=32; assert reset mid-RUN → next cycle busy=0, done=0, product_lo=product_hi=0; then a=0xFFFFFFFF, b=0xFFFFFFFF → product_hi=0xFFFFFFFE, product_lo=0x00000001 after 33 cycles.
